hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

Pipeline hazard controller for the five-stage integer pipeline. It sits beside the decode stage and holds its own shadow copy of the EX, MEM and WB destination registers. Each cycle it decides whether the instruction in decode issues, stalls or is replaced by a bubble. It also sequences multi-cycle multiplies that occupy EX, and produces registered operand-forwarding selects for the execute stage.

## Interface
Parameters:
- `MULT_LAT`, 4: cycles a multiply occupies EX; legal range 2..15.

Ports:
- `clk`  in  1  pipeline clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `id_valid`  in  1  the decode latch holds a real instruction.
- `id_rs`, `id_rt`  in  5 each  source register numbers of the decode instruction.
- `id_uses_rt`  in  1  `rt` is a source, not a destination.
- `id_writes`  in  1  the instruction writes `id_dest`.
- `id_dest`  in  5  destination register number.
- `id_is_load`  in  1  the instruction is a load.
- `id_is_mult`  in  1  the instruction is a multi-cycle multiply.
- `ex_flush`  in  1  taken branch resolved in EX; kills the decode instruction.
- `stall`  out  1  hold PC and the IF/ID latch this cycle.
- `bubble`  out  1  zero the control bits entering the ID/EX latch this cycle.
- `issue`  out  1  the decode instruction advances to EX this edge.
- `fwd_a`, `fwd_b`  out  2 each  EX operand select: 00 register file, 01 EX/MEM latch, 10 MEM/WB latch, 11 WB hold register.
- `busy`  out  1  a multiply occupies EX.

## Operation
- The shadow pipeline has three slots: EX, MEM and WB. Each slot holds {valid, dest, is_load}.
  - An issued instruction enters EX only if `id_writes` is set and `id_dest != 0`. Otherwise it enters EX with valid=0.
  - On every non-frozen edge the slots shift EX→MEM→WB.
  - A bubble enters EX as valid=0.
- A hazard match is a valid slot whose `dest` is nonzero and equals `id_rs`, or equals `id_rt` when `id_uses_rt`=1. Register 0 never matches.
- Load-use stall: the EX slot is a valid load and matches → `stall`=1, `bubble`=1 for one cycle.
- FSM states are IDLE and MBUSY.
  - IDLE→MBUSY when a multiply issues. The counter loads MULT_LAT-1.
  - In MBUSY:
    - `stall`=1 and `busy`=1.
    - The EX slot is frozen.
    - MEM receives valid=0 each cycle while WB still advances.
    - The counter decrements each cycle.
  - When the counter is 0, the next state is IDLE and normal advance resumes on the following edge.
- Priority order: MBUSY stall, then `ex_flush`, then load-use stall, then issue.
- `ex_flush`=1 (state IDLE) → `bubble`=1, `stall`=0, `issue`=0. The decode instruction is discarded. The slots still shift.
- `ex_flush` in MBUSY cannot occur because EX holds the multiply. It is ignored; the bench asserts it never occurs.
- `issue` = `id_valid` & ~`stall` & ~`ex_flush`.
- Forwarding is computed at issue and registered into `fwd_a`/`fwd_b` for the instruction's EX cycle. Lookup order:
  - EX-slot match → 01.
  - else MEM-slot match → 10.
  - else WB-slot match → 11.
  - else 00.
- `fwd_*` hold their value while stalled and clear to 00 on a bubble.

## Timing
- `stall`, `bubble` and `issue` are combinational from the current state and the decode inputs, within the same cycle.
- `fwd_*`, `busy` and the FSM are registered, so they update one edge after issue.
- A load-use stall costs exactly 1 cycle. A multiply blocks decode for MULT_LAT cycles after its issue edge.
- Reset (asynchronous, any time, including mid-multiply) gives: state IDLE, counter 0, all slots invalid, `fwd_*`=00, `busy`=0. `stall`, `bubble` and `issue` then follow their equations; `issue` is set if `id_valid`=1.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding as described; only load-use and multiply hazards stall.
- `HAZARD_FWD_EN` undefined:
  - `fwd_*` are tied to 00.
  - Any match in EX, MEM or WB stalls with a bubble until the producer leaves WB. This is up to 3 cycles.

## Structure
- The shared package `pipe_pkg` holds the forwarding-select constants (FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_WB), the FSM state enum and the slot struct.
- One sub-module, `hazard_match`, is combinational. It compares a slot against rs/rt and outputs a per-operand hit. It is instantiated three times.

## Test plan
- `lw $5` issued, then `add $6,$5,$7` → 1 cycle with `stall`=1, `bubble`=1, then issue with `fwd_a`=10.
- `add $3,..`, then `sub $4,$3,$3` back-to-back → no stall; `fwd_a`=`fwd_b`=01.
- `mult` with MULT_LAT=4, then `add` → `busy` high for 4 cycles and `stall` high for 4 cycles, then the add issues.
- Producer writes $0, then consumer of $0 → no stall; `fwd_a`=00.
- `ex_flush`=1 coinciding with a load-use condition → `bubble`=1, `stall`=0, `issue`=0.
- `rst_n` pulsed low in the 2nd MBUSY cycle → `busy`=0 and `fwd_*`=00 immediately. Then the next valid decode instruction issues.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding-select codes, hazard FSM states
// and the shadow-slot record used by the hazard scheduler.
package pipe_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_WB    = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MBUSY = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, dest: 5'd0, is_load: 1'b0};

  // Youngest producer wins: bit 0 = EX, bit 1 = MEM, bit 2 = WB.
  function automatic logic [1:0] fwd_select(input logic [2:0] hits);
    if (hits[0]) return FWD_EXMEM;
    else if (hits[1]) return FWD_MEMWB;
    else if (hits[2]) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one shadow slot's destination against the decode sources and
// reports a hit per operand. Register 0 is hard-wired and never matches.
module hazard_match (
  input  logic       slot_valid,
  input  logic [4:0] slot_dest,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rt,
  output logic       hit_a,
  output logic       hit_b
);

  logic live;

  // A slot only counts when it really writes a nonzero register.
  always_comb begin
    live  = slot_valid && (slot_dest != 5'd0);
    hit_a = live && (slot_dest == rs);
    hit_b = live && uses_rt && (slot_dest == rt);
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Decode-side hazard controller for the five-stage pipeline. Tracks a shadow
// copy of EX/MEM/WB destinations, decides issue/stall/bubble, sequences
// multi-cycle multiplies and registers the EX operand-forwarding selects.
// Build option: define HAZARD_FWD_EN to enable operand forwarding; without
// it every register dependency stalls until the producer has left WB.
module hazard_scheduler
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_writes,
  input  logic [4:0] id_dest,
  input  logic       id_is_load,
  input  logic       id_is_mult,
  input  logic       ex_flush,
  output logic       stall,
  output logic       bubble,
  output logic       issue,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       busy
);

  localparam logic [3:0] CNT_LOAD = 4'(MULT_LAT - 1);

  hz_state_e  state, state_nxt;
  logic [3:0] cnt;
  slot_t      ex_slot, mem_slot, wb_slot, ex_in;
  logic [2:0] hit_a, hit_b;
  logic       hazard;
  logic       mult_busy;
  logic       unused_wb_load;

  assign mult_busy      = (state == MBUSY);
  assign busy           = mult_busy;
  assign unused_wb_load = wb_slot.is_load;

  hazard_match u_match_ex (
    .slot_valid (ex_slot.valid),
    .slot_dest  (ex_slot.dest),
    .rs         (id_rs),
    .rt         (id_rt),
    .uses_rt    (id_uses_rt),
    .hit_a      (hit_a[0]),
    .hit_b      (hit_b[0])
  );

  hazard_match u_match_mem (
    .slot_valid (mem_slot.valid),
    .slot_dest  (mem_slot.dest),
    .rs         (id_rs),
    .rt         (id_rt),
    .uses_rt    (id_uses_rt),
    .hit_a      (hit_a[1]),
    .hit_b      (hit_b[1])
  );

  hazard_match u_match_wb (
    .slot_valid (wb_slot.valid),
    .slot_dest  (wb_slot.dest),
    .rs         (id_rs),
    .rt         (id_rt),
    .uses_rt    (id_uses_rt),
    .hit_a      (hit_a[2]),
    .hit_b      (hit_b[2])
  );

  // Dependency stall condition: only a load in EX with forwarding, any producer still in flight without.
  always_comb begin
`ifdef HAZARD_FWD_EN
    hazard = id_valid && ex_slot.is_load && (hit_a[0] || hit_b[0]);
`else
    hazard = id_valid && (|(hit_a | hit_b));
`endif
  end

  // Issue decision; a running multiply outranks a flush, which outranks a dependency stall.
  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    issue  = 1'b0;
    if (mult_busy) begin
      stall = 1'b1;
    end else if (ex_flush) begin
      bubble = 1'b1;
    end else if (hazard) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end else begin
      issue = id_valid;
    end
  end

  // Record entering EX: only a real register write leaves a trace.
  always_comb begin
    ex_in = SLOT_EMPTY;
    if (issue && id_writes && (id_dest != 5'd0)) begin
      ex_in = '{valid: 1'b1, dest: id_dest, is_load: id_is_load};
    end
  end

  // Multiply FSM: stay busy until the cycle counter has run down to zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue && id_is_mult) state_nxt = MBUSY;
      MBUSY:   if (cnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and multiply cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (!mult_busy && issue && id_is_mult) begin
        cnt <= CNT_LOAD;
      end else if (mult_busy && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Shadow pipeline; EX is pinned by a running multiply while WB keeps draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_slot  <= SLOT_EMPTY;
      mem_slot <= SLOT_EMPTY;
      wb_slot  <= SLOT_EMPTY;
    end else if (mult_busy) begin
      mem_slot <= SLOT_EMPTY;
      wb_slot  <= mem_slot;
    end else begin
      ex_slot  <= ex_in;
      mem_slot <= ex_slot;
      wb_slot  <= mem_slot;
    end
  end

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a_q, fwd_b_q;

  // Capture selects at issue; hold while a multiply owns EX, otherwise read the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (issue) begin
      fwd_a_q <= fwd_select(hit_a);
      fwd_b_q <= fwd_select(hit_b);
    end else if (!mult_busy) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: directed scenarios plus a
// randomized run, all compared against an in-bench model of in-flight
// instructions. Follows HAZARD_FWD_EN the same way the design does.
module tb_hazard_scheduler;

  localparam int MULT_LAT = 4;
`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
  localparam int LOAD_DEP_STALLS = 1;
  localparam int ALU_DEP_STALLS = 0;
`else
  localparam bit FWD_EN = 1'b0;
  localparam int LOAD_DEP_STALLS = 3;
  localparam int ALU_DEP_STALLS = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_rt, id_writes, id_is_load, id_is_mult, ex_flush;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       stall, bubble, issue, busy;
  logic [1:0] fwd_a, fwd_b;

  always #5 clk = ~clk;

  hazard_scheduler #(.MULT_LAT(MULT_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .id_writes  (id_writes),
    .id_dest    (id_dest),
    .id_is_load (id_is_load),
    .id_is_mult (id_is_mult),
    .ex_flush   (ex_flush),
    .stall      (stall),
    .bubble     (bubble),
    .issue      (issue),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .busy       (busy)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       wr;
    logic [4:0] dest;
    logic       ld;
    logic       mul;
    logic       fl;
  } op_t;

  typedef struct packed {
    logic       v;
    logic [4:0] d;
    logic       ld;
  } inflight_t;

  // Reference model: in-flight writers (index 0 = EX, 1 = MEM, 2 = WB).
  inflight_t  pipe_q[$];
  int         mult_left;
  logic [1:0] m_fwd_a, m_fwd_b;
  logic       e_stall, e_bubble, e_issue, e_busy;
  int         checks, errors;

  function automatic op_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic urt, logic wr,
                             logic [4:0] dest, logic ld, logic mul, logic fl);
    op_t o;
    o.v = v; o.rs = rs; o.rt = rt; o.urt = urt; o.wr = wr;
    o.dest = dest; o.ld = ld; o.mul = mul; o.fl = fl;
    return o;
  endfunction

  function automatic logic [7:0] obs_vec();
    return {stall, bubble, issue, busy, fwd_a, fwd_b};
  endfunction

  function automatic logic [7:0] exp_vec();
    return {e_stall, e_bubble, e_issue, e_busy, m_fwd_a, m_fwd_b};
  endfunction

  function automatic bit match_at(int i);
    return pipe_q[i].v && (pipe_q[i].d != 5'd0) &&
           ((pipe_q[i].d == id_rs) || (id_uses_rt && (pipe_q[i].d == id_rt)));
  endfunction

  // Forwarding code is simply 1 + age of the youngest matching writer.
  function automatic logic [1:0] m_lookup(logic [4:0] r, logic en);
    if (!en || (r == 5'd0)) return 2'b00;
    for (int i = 0; i < 3; i++) begin
      if (pipe_q[i].v && (pipe_q[i].d == r)) return 2'(i + 1);
    end
    return 2'b00;
  endfunction

  task automatic model_reset();
    pipe_q = {};
    repeat (3) pipe_q.push_back('0);
    mult_left = 0;
    m_fwd_a = 2'b00;
    m_fwd_b = 2'b00;
  endtask

  task automatic predict();
    bit hz;
    hz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (match_at(i) && (!FWD_EN || (i == 0 && pipe_q[0].ld))) hz = 1'b1;
    end
    hz = hz && id_valid;
    e_busy = (mult_left > 0);
    if (mult_left > 0) begin
      e_stall = 1'b1; e_bubble = 1'b0; e_issue = 1'b0;
    end else if (ex_flush) begin
      e_stall = 1'b0; e_bubble = 1'b1; e_issue = 1'b0;
    end else if (hz) begin
      e_stall = 1'b1; e_bubble = 1'b1; e_issue = 1'b0;
    end else begin
      e_stall = 1'b0; e_bubble = 1'b0; e_issue = id_valid;
    end
  endtask

  task automatic model_edge();
    inflight_t n;
    if (mult_left > 0) begin
      pipe_q[2] = pipe_q[1];
      pipe_q[1] = '0;
      mult_left--;
    end else begin
      if (e_issue && FWD_EN) begin
        m_fwd_a = m_lookup(id_rs, 1'b1);
        m_fwd_b = m_lookup(id_rt, id_uses_rt);
      end else begin
        m_fwd_a = 2'b00;
        m_fwd_b = 2'b00;
      end
      n = '0;
      if (e_issue && id_writes && (id_dest != 5'd0)) n = '{v: 1'b1, d: id_dest, ld: id_is_load};
      pipe_q.push_front(n);
      void'(pipe_q.pop_back());
      if (e_issue && id_is_mult) mult_left = MULT_LAT;
    end
  endtask

  task automatic set_in(input op_t o);
    id_valid = o.v; id_rs = o.rs; id_rt = o.rt; id_uses_rt = o.urt;
    id_writes = o.wr; id_dest = o.dest; id_is_load = o.ld;
    id_is_mult = o.mul; ex_flush = o.fl;
  endtask

  task automatic drive(input op_t o);
    set_in(o);
    predict();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in('0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    predict();
    advance();
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && busy === 1'b1 && ex_flush === 1'b1)
      $error("[TB] ex_flush driven while a multiply occupies EX");
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    set_in(mk(1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0));
    predict();
    #1;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL reset_model: got %b want %b", obs_vec(), exp_vec());
    end
    checks++;
    if (obs_vec() !== 8'b0010_0000) begin
      errors++;
      $display("[TB] FAIL reset_values: got %b want 00100000", obs_vec());
    end
    do_reset();
  endtask

  task automatic test_load_use();
    op_t prog[2];
    int  n, stalls;
    do_reset();
    prog[0] = mk(1, 5'd1, 5'd2, 0, 1, 5'd5, 1, 0, 0);
    prog[1] = mk(1, 5'd5, 5'd7, 1, 1, 5'd6, 0, 0, 0);
    stalls = 0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        drive(prog[k]);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("[TB] FAIL load_use[%0d]: got %b want %b", k, obs_vec(), exp_vec());
        end
        if (k == 1 && stall === 1'b1) stalls++;
        advance();
        n++;
      end while (!e_issue && n < 12);
      if (!e_issue) begin errors++; $display("[TB] FAIL load_use_timeout: issued=0 want 1"); end
    end
    drive('0);
    checks++;
    if (stalls != LOAD_DEP_STALLS) begin
      errors++;
      $display("[TB] FAIL load_use_stall_cycles: got %0d want %0d", stalls, LOAD_DEP_STALLS);
    end
    checks++;
    if (fwd_a !== (FWD_EN ? 2'b10 : 2'b00)) begin
      errors++;
      $display("[TB] FAIL load_use_fwd_a: got %b want %b", fwd_a, FWD_EN ? 2'b10 : 2'b00);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    op_t prog[2];
    int  n, stalls;
    do_reset();
    prog[0] = mk(1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0);
    prog[1] = mk(1, 5'd3, 5'd3, 1, 1, 5'd4, 0, 0, 0);
    stalls = 0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        drive(prog[k]);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("[TB] FAIL back_to_back[%0d]: got %b want %b", k, obs_vec(), exp_vec());
        end
        if (k == 1 && stall === 1'b1) stalls++;
        advance();
        n++;
      end while (!e_issue && n < 12);
      if (!e_issue) begin errors++; $display("[TB] FAIL back_to_back_timeout: issued=0 want 1"); end
    end
    drive('0);
    checks++;
    if (stalls != ALU_DEP_STALLS) begin
      errors++;
      $display("[TB] FAIL back_to_back_stalls: got %0d want %0d", stalls, ALU_DEP_STALLS);
    end
    checks++;
    if ({fwd_a, fwd_b} !== (FWD_EN ? 4'b0101 : 4'b0000)) begin
      errors++;
      $display("[TB] FAIL back_to_back_fwd: got %b%b want %b", fwd_a, fwd_b, FWD_EN ? 4'b0101 : 4'b0000);
    end
    advance();
  endtask

  task automatic test_mult();
    op_t prog[2];
    int  n, stalls, busys;
    do_reset();
    prog[0] = mk(1, 5'd1, 5'd2, 1, 1, 5'd8, 0, 1, 0);
    prog[1] = mk(1, 5'd9, 5'd10, 1, 1, 5'd11, 0, 0, 0);
    stalls = 0;
    busys = 0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        drive(prog[k]);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("[TB] FAIL mult[%0d]: got %b want %b", k, obs_vec(), exp_vec());
        end
        if (k == 1 && stall === 1'b1) stalls++;
        if (k == 1 && busy === 1'b1) busys++;
        advance();
        n++;
      end while (!e_issue && n < 20);
      if (!e_issue) begin errors++; $display("[TB] FAIL mult_timeout: issued=0 want 1"); end
    end
    checks++;
    if (stalls != MULT_LAT || busys != MULT_LAT) begin
      errors++;
      $display("[TB] FAIL mult_cycles: stall=%0d busy=%0d want %0d each", stalls, busys, MULT_LAT);
    end
    drive('0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mult_busy_after: got %b want 0", busy);
    end
    advance();
  endtask

  task automatic test_zero_reg();
    op_t prog[2];
    int  n;
    do_reset();
    prog[0] = mk(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 0);
    prog[1] = mk(1, 5'd0, 5'd0, 1, 1, 5'd12, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        drive(prog[k]);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("[TB] FAIL zero_reg[%0d]: got %b want %b", k, obs_vec(), exp_vec());
        end
        checks++;
        if (stall !== 1'b0) begin
          errors++;
          $display("[TB] FAIL zero_reg_stall[%0d]: got %b want 0", k, stall);
        end
        advance();
        n++;
      end while (!e_issue && n < 12);
    end
    drive('0);
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL zero_reg_fwd: got %b%b want 0000", fwd_a, fwd_b);
    end
    advance();
  endtask

  task automatic test_flush();
    do_reset();
    drive(mk(1, 5'd1, 5'd2, 0, 1, 5'd5, 1, 0, 0));
    advance();
    drive(mk(1, 5'd5, 5'd7, 1, 1, 5'd6, 0, 0, 1));
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL flush_model: got %b want %b", obs_vec(), exp_vec());
    end
    checks++;
    if ({stall, bubble, issue} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL flush_ctrl: got %b want 010", {stall, bubble, issue});
    end
    advance();
    drive('0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL flush_after: got %b want %b", obs_vec(), exp_vec());
    end
    advance();
  endtask

  task automatic test_reset_mid_mult();
    op_t prod, mul, nxt;
    int  n;
    do_reset();
    prod = mk(1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0);
    mul  = mk(1, 5'd3, 5'd4, 1, 1, 5'd8, 0, 1, 0);
    nxt  = mk(1, 5'd9, 5'd10, 1, 1, 5'd11, 0, 0, 0);
    drive(prod);
    advance();
    n = 0;
    do begin
      drive(mul);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL rst_mult_issue: got %b want %b", obs_vec(), exp_vec());
      end
      advance();
      n++;
    end while (!e_issue && n < 12);
    drive(nxt);
    advance();
    #2;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_mult_busy_before: got %b want 1", busy);
    end
    rst_n = 1'b0;
    model_reset();
    predict();
    #1;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL rst_mult_async: got %b want %b", obs_vec(), exp_vec());
    end
    checks++;
    if ({busy, fwd_a, fwd_b, issue} !== 6'b000001) begin
      errors++;
      $display("[TB] FAIL rst_mult_values: got %b want 000001", {busy, fwd_a, fwd_b, issue});
    end
    @(negedge clk);
    rst_n = 1'b1;
    predict();
    #1;
    checks++;
    if (issue !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mult_next_issue: got issue=%b stall=%b want 1 0", issue, stall);
    end
    advance();
    drive('0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL rst_mult_after: got %b want %b", obs_vec(), exp_vec());
    end
    advance();
  endtask

  task automatic test_random();
    op_t cur;
    bit  need_new;
    do_reset();
    need_new = 1'b1;
    cur = '0;
    for (int c = 0; c < 600; c++) begin
      if (need_new) begin
        cur.v    = ($urandom_range(0, 7) != 0);
        cur.rs   = 5'($urandom_range(0, 7));
        cur.rt   = 5'($urandom_range(0, 7));
        cur.urt  = 1'($urandom_range(0, 1));
        cur.wr   = ($urandom_range(0, 3) != 0);
        cur.dest = 5'($urandom_range(0, 7));
        cur.mul  = ($urandom_range(0, 9) == 0);
        cur.ld   = !cur.mul && ($urandom_range(0, 3) == 0);
      end
      cur.fl = (mult_left == 0) && ($urandom_range(0, 9) == 0);
      drive(cur);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random[%0d]: got %b want %b", c, obs_vec(), exp_vec());
      end
      need_new = e_issue || cur.fl || !cur.v;
      advance();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    set_in('0);
    test_reset();
    test_load_use();
    test_back_to_back();
    test_mult();
    test_zero_reg();
    test_flush();
    test_reset_mid_mult();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
